// File: rtl/carregador_programa_if.sv
// Stream and instruction-memory write bus of the program loader.
// The stream source (master) drives rx_valid/rx_data and observes rx_ready.
// The loader (slave) answers with rx_ready and drives the memory write port.
interface carregador_programa_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) ();
   logic              rx_valid;
   logic [DATA_W-1:0] rx_data;
   logic              rx_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   modport master (
      output rx_valid,
      output rx_data,
      input  rx_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );

   modport slave (
      input  rx_valid,
      input  rx_data,
      output rx_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );
endinterface

// File: rtl/carregador_programa.sv
// Program loader: receives a framed byte stream (LEN, N data bytes and an
// optional checksum byte) over a valid/ready handshake, writes the data
// words into instruction memory and keeps the core halted until the frame
// has been fully received.
//
// Optional feature macro: CARREGADOR_CHECKSUM_EN
//   defined   -> a checksum byte follows the data; mismatch parks the loader
//                in ERROR with load_err=1 and the core halted.
//   undefined -> the core is released right after the last data byte and
//                load_err is constant 0.
module carregador_programa #(
   parameter int                ADDR_W    = 8,
   parameter int                DATA_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load_req,
   carregador_programa_if.slave   bus,
   output logic                   cpu_run,
   output logic                   load_err
);

   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

   typedef enum logic [2:0] {
      ST_LEN   = 3'd0,
      ST_DATA  = 3'd1,
      ST_CSUM  = 3'd2,
      ST_RUN   = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   // Registered state
   state_t            state_r;
   logic [ADDR_W-1:0] len_r;
   logic [ADDR_W-1:0] count_r;
   logic [DATA_W-1:0] sum_r;
   logic              mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic              cpu_run_r;

   // Next-state values
   state_t            state_next_s;
   logic [ADDR_W-1:0] len_next_s;
   logic [ADDR_W-1:0] count_next_s;
   logic [DATA_W-1:0] sum_next_s;
   logic              mem_we_next_s;
   logic [ADDR_W-1:0] mem_addr_next_s;
   logic [DATA_W-1:0] mem_wdata_next_s;
   logic              cpu_run_next_s;

   logic              rx_ready_s;
   logic              accept_s;
   logic              last_data_s;

`ifdef CARREGADOR_CHECKSUM_EN
   logic              load_err_r;
   logic              load_err_next_s;
`endif

   // Handshake: ready in the receiving states, forced low while a restart is requested
   always_comb begin
      rx_ready_s  = 1'b0;
      accept_s    = 1'b0;
      last_data_s = 1'b0;
      if (load_req) begin
         rx_ready_s = 1'b0;
      end else if ((state_r == ST_LEN) || (state_r == ST_DATA) || (state_r == ST_CSUM)) begin
         rx_ready_s = 1'b1;
      end else begin
         rx_ready_s = 1'b0;
      end
      accept_s = bus.rx_valid & rx_ready_s;
      // LEN=0 encodes 2^ADDR_W words: len-1 then wraps to all ones, which is
      // exactly the last index, so a single compare covers every length.
      if (count_r == (len_r - ADDR_ONE)) begin
         last_data_s = 1'b1;
      end else begin
         last_data_s = 1'b0;
      end
   end

   // Next-state and next-output logic of the frame receiver
   always_comb begin
      state_next_s     = state_r;
      len_next_s       = len_r;
      count_next_s     = count_r;
      sum_next_s       = sum_r;
      mem_we_next_s    = 1'b0;
      mem_addr_next_s  = mem_addr_r;
      mem_wdata_next_s = mem_wdata_r;

      if (load_req) begin
         // Restart wins over everything; a write registered last cycle is
         // already on the bus this cycle and is not cancelled.
         state_next_s = ST_LEN;
         count_next_s = ADDR_ZERO;
         sum_next_s   = DATA_ZERO;
      end else begin
         case (state_r)
            ST_LEN: begin
               if (accept_s) begin
                  len_next_s   = ADDR_W'(bus.rx_data);
                  count_next_s = ADDR_ZERO;
                  sum_next_s   = DATA_ZERO;
                  state_next_s = ST_DATA;
               end else begin
                  state_next_s = ST_LEN;
               end
            end
            ST_DATA: begin
               if (accept_s) begin
                  mem_we_next_s    = 1'b1;
                  mem_addr_next_s  = BASE_ADDR + count_r;
                  mem_wdata_next_s = bus.rx_data;
                  sum_next_s       = sum_r + bus.rx_data;
                  count_next_s     = count_r + ADDR_ONE;
                  if (last_data_s) begin
`ifdef CARREGADOR_CHECKSUM_EN
                     state_next_s = ST_CSUM;
`else
                     state_next_s = ST_RUN;
`endif
                  end else begin
                     state_next_s = ST_DATA;
                  end
               end else begin
                  state_next_s = ST_DATA;
               end
            end
`ifdef CARREGADOR_CHECKSUM_EN
            ST_CSUM: begin
               if (accept_s) begin
                  if (bus.rx_data == sum_r) begin
                     state_next_s = ST_RUN;
                  end else begin
                     state_next_s = ST_ERROR;
                  end
               end else begin
                  state_next_s = ST_CSUM;
               end
            end
            ST_ERROR: begin
               state_next_s = ST_ERROR;
            end
`endif
            ST_RUN: begin
               state_next_s = ST_RUN;
            end
            default: begin
               state_next_s = ST_LEN;
            end
         endcase
      end

      // Status outputs follow the state being entered so they are valid
      // in the very cycle after the final accept.
      if (state_next_s == ST_RUN) begin
         cpu_run_next_s = 1'b1;
      end else begin
         cpu_run_next_s = 1'b0;
      end
`ifdef CARREGADOR_CHECKSUM_EN
      if (state_next_s == ST_ERROR) begin
         load_err_next_s = 1'b1;
      end else begin
         load_err_next_s = 1'b0;
      end
`endif
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_LEN;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Frame bookkeeping and registered memory/status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_r       <= ADDR_ZERO;
         count_r     <= ADDR_ZERO;
         sum_r       <= DATA_ZERO;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= BASE_ADDR;
         mem_wdata_r <= DATA_ZERO;
         cpu_run_r   <= 1'b0;
      end else begin
         len_r       <= len_next_s;
         count_r     <= count_next_s;
         sum_r       <= sum_next_s;
         mem_we_r    <= mem_we_next_s;
         mem_addr_r  <= mem_addr_next_s;
         mem_wdata_r <= mem_wdata_next_s;
         cpu_run_r   <= cpu_run_next_s;
      end
   end

`ifdef CARREGADOR_CHECKSUM_EN
   // Checksum error flag, held until restart or reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_err_r <= 1'b0;
      end else begin
         load_err_r <= load_err_next_s;
      end
   end
   assign load_err = load_err_r;
`else
   assign load_err = 1'b0;
`endif

   assign bus.rx_ready  = rx_ready_s;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign cpu_run       = cpu_run_r;

endmodule
